// File: rtl/crtc_pkg.sv
// Shared definitions for the CRT controller: register indices, reset defaults and
// the vertical sequencing states.
package crtc_pkg;

  localparam logic [4:0] IdxHtotal    = 5'd0;
  localparam logic [4:0] IdxHdisp     = 5'd1;
  localparam logic [4:0] IdxHsyncPos  = 5'd2;
  localparam logic [4:0] IdxSyncWidth = 5'd3;
  localparam logic [4:0] IdxVtotal    = 5'd4;
  localparam logic [4:0] IdxVadj      = 5'd5;
  localparam logic [4:0] IdxVdisp     = 5'd6;
  localparam logic [4:0] IdxVsyncPos  = 5'd7;
  localparam logic [4:0] IdxMaxRas    = 5'd9;
  localparam logic [4:0] IdxStartHi   = 5'd12;
  localparam logic [4:0] IdxStartLo   = 5'd13;

  typedef enum logic {StRows, StAdj} vstate_e;

  typedef struct packed {
    logic [7:0] htotal;
    logic [7:0] hdisp;
    logic [7:0] hsyncpos;
    logic [3:0] vsw;
    logic [3:0] hsw;
    logic [6:0] vtotal;
    logic [4:0] vadj;
    logic [6:0] vdisp;
    logic [6:0] vsyncpos;
    logic [4:0] maxras;
    logic [5:0] start_hi;
    logic [7:0] start_lo;
  } crtc_cfg_t;

  localparam crtc_cfg_t CfgDefault = '{
    htotal:   8'd63,
    hdisp:    8'd32,
    hsyncpos: 8'd44,
    vsw:      4'h2,
    hsw:      4'h8,
    vtotal:   7'd30,
    vadj:     5'd2,
    vdisp:    7'd31,
    vsyncpos: 7'd31,
    maxras:   5'd7,
    start_hi: 6'd0,
    start_lo: 8'd0
  };

endpackage

// File: rtl/crtc_regs.sv
// CRTC register file: an index register plus the timing registers, written through
// a two-step address/data CPU port. Only the start address is readable.
module crtc_regs
  import crtc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rs,
  input  logic [7:0] di,
  output crtc_cfg_t  cfg,
  output logic [7:0] dout
);

  logic [4:0] idx_q;
  crtc_cfg_t  cfg_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= 5'd0;
      cfg_q <= CfgDefault;
    end else if (cs) begin
      if (!rs) begin
        idx_q <= di[4:0];
      end else begin
        case (idx_q)
          IdxHtotal:    cfg_q.htotal   <= di;
          IdxHdisp:     cfg_q.hdisp    <= di;
          IdxHsyncPos:  cfg_q.hsyncpos <= di;
          IdxSyncWidth: begin
            cfg_q.vsw <= di[7:4];
            cfg_q.hsw <= di[3:0];
          end
          IdxVtotal:    cfg_q.vtotal   <= di[6:0];
          IdxVadj:      cfg_q.vadj     <= di[4:0];
          IdxVdisp:     cfg_q.vdisp    <= di[6:0];
          IdxVsyncPos:  cfg_q.vsyncpos <= di[6:0];
          IdxMaxRas:    cfg_q.maxras   <= di[4:0];
          IdxStartHi:   cfg_q.start_hi <= di[5:0];
          IdxStartLo:   cfg_q.start_lo <= di;
          default:      ;
        endcase
      end
    end
  end

  always_comb begin
    dout = 8'h00;
    if (idx_q == IdxStartHi) begin
      dout = {2'b00, cfg_q.start_hi};
    end else if (idx_q == IdxStartLo) begin
      dout = cfg_q.start_lo;
    end
  end

  assign cfg = cfg_q;

endmodule

// File: rtl/crtc.sv
// CRT controller timing core: character/raster/row counters, vertical adjust FSM,
// sync pulse generators and memory address sequencing.
module crtc
  import crtc_pkg::*;
#(
  parameter int unsigned MA_W = 14
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic            cs,
  input  logic            rs,
  input  logic [7:0]      di,
  output logic [7:0]      dout,  // "do" is a reserved word
  output logic            de,
  output logic            hsync,
  output logic            vsync,
  output logic [MA_W-1:0] ma,
  output logic [4:0]      ra
);

  localparam logic [MA_W-1:0] StartDefault = MA_W'({CfgDefault.start_hi, CfgDefault.start_lo});

  crtc_cfg_t cfg;

  crtc_regs u_regs (
    .clock (clock),
    .reset (reset),
    .cs    (cs),
    .rs    (rs),
    .di    (di),
    .cfg   (cfg),
    .dout  (dout)
  );

  logic [7:0]      hc_q, hc_d;
  logic [4:0]      ra_q, ra_d;
  logic [6:0]      vc_q, vc_d;
  logic [4:0]      adj_q, adj_d;
  vstate_e         st_q, st_d;
  logic [3:0]      hs_q, hs_d;
  logic [4:0]      vs_q, vs_d;
  logic [MA_W-1:0] ma_q, ma_d;
  logic [MA_W-1:0] base_q, base_d;
  logic [MA_W-1:0] start;
  logic            line_end, row_end, frame_end;

  assign start = MA_W'({cfg.start_hi, cfg.start_lo});

  // Magnitude compares let a shrunken total take effect on the next wrap.
  assign line_end = hc_q >= cfg.htotal;
  assign row_end  = ra_q >= cfg.maxras;

  always_comb begin
    hc_d      = hc_q;
    ra_d      = ra_q;
    vc_d      = vc_q;
    adj_d     = adj_q;
    st_d      = st_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    ma_d      = ma_q;
    base_d    = base_q;
    frame_end = 1'b0;

    if (ce) begin
      hc_d = line_end ? 8'd0 : hc_q + 8'd1;
      ma_d = ma_q + MA_W'(1);
      if (st_q == StRows && row_end && hc_q == cfg.hdisp) begin
        base_d = ma_q;
      end

      if (hc_d == cfg.hsyncpos) begin
        hs_d = cfg.hsw;
      end else if (hs_q != 4'd0) begin
        hs_d = hs_q - 4'd1;
      end

      if (line_end) begin
        ma_d = base_d;
        unique case (st_q)
          StRows: begin
            if (row_end) begin
              ra_d = 5'd0;
              if (vc_q >= cfg.vtotal) begin
                if (cfg.vadj != 5'd0) begin
                  // Adjust lines sit on the row after the last one, so vsync can land there.
                  st_d  = StAdj;
                  vc_d  = vc_q + 7'd1;
                  adj_d = 5'd0;
                end else begin
                  frame_end = 1'b1;
                end
              end else begin
                vc_d = vc_q + 7'd1;
              end
            end else begin
              ra_d = ra_q + 5'd1;
            end
          end
          StAdj: begin
            if ({1'b0, adj_q} + 6'd1 >= {1'b0, cfg.vadj}) begin
              frame_end = 1'b1;
            end else begin
              adj_d = adj_q + 5'd1;
              ra_d  = ra_q + 5'd1;
            end
          end
        endcase

        if (frame_end) begin
          st_d   = StRows;
          vc_d   = 7'd0;
          ra_d   = 5'd0;
          adj_d  = 5'd0;
          ma_d   = start;
          base_d = start;
        end

        if (vc_d == cfg.vsyncpos && ra_d == 5'd0) begin
          vs_d = (cfg.vsw == 4'd0) ? 5'd16 : {1'b0, cfg.vsw};
        end else if (vs_q != 5'd0) begin
          vs_d = vs_q - 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hc_q   <= 8'd0;
      ra_q   <= 5'd0;
      vc_q   <= 7'd0;
      adj_q  <= 5'd0;
      st_q   <= StRows;
      hs_q   <= 4'd0;
      vs_q   <= 5'd0;
      ma_q   <= StartDefault;
      base_q <= StartDefault;
    end else begin
      hc_q   <= hc_d;
      ra_q   <= ra_d;
      vc_q   <= vc_d;
      adj_q  <= adj_d;
      st_q   <= st_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      ma_q   <= ma_d;
      base_q <= base_d;
    end
  end

  assign de    = (hc_q < cfg.hdisp) && (vc_q < cfg.vdisp) && (st_q == StRows);
  assign hsync = hs_q != 4'd0;
  assign vsync = vs_q != 5'd0;
  assign ma    = ma_q;
  assign ra    = ra_q;

endmodule

// File: tb/tb_crtc.sv
// Directed bench for the CRT controller: line/frame timing, start address, register
// writes mid-line and reset priority, with hand-computed expectations.
module tb_crtc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce    = 1'b0;
  logic        cs    = 1'b0;
  logic        rs    = 1'b0;
  logic [7:0]  di    = 8'h00;
  logic [7:0]  dout;
  logic        de, hsync, vsync;
  logic [13:0] ma;
  logic [4:0]  ra;

  int checks = 0;
  int errors = 0;

  crtc #(.MA_W(14)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .cs    (cs),
    .rs    (rs),
    .di    (di),
    .dout  (dout),
    .de    (de),
    .hsync (hsync),
    .vsync (vsync),
    .ma    (ma),
    .ra    (ra)
  );

  always #5 clock = ~clock;

  task automatic step(input logic c);
    ce = c;
    @(posedge clock);
    #1;
    ce = 1'b0;
  endtask

  task automatic ces(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    reset = 1'b0;
  endtask

  task automatic sel(input logic [4:0] idx);
    cs = 1'b1; rs = 1'b0; di = {3'b000, idx};
    @(posedge clock); #1;
    cs = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [7:0] val);
    sel(idx);
    cs = 1'b1; rs = 1'b1; di = val;
    @(posedge clock); #1;
    cs = 1'b0; rs = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL reset_de got %b want 1", de); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync got %b want 0", hsync); end
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync got %b want 0", vsync); end
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL reset_ma got %h want 0", ma); end
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL reset_ra got %0d want 0", ra); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_do got %h want 00", dout); end
  endtask

  // ce every 8 clocks over one default line.
  task automatic test_line();
    logic exp_de, exp_hs;
    do_reset();
    for (int k = 0; k < 64; k++) begin
      exp_de = (k < 32);
      exp_hs = (k >= 44) && (k <= 51);
      checks++; if (de !== exp_de) begin errors++; $display("FAIL line_de hc=%0d got %b want %b", k, de, exp_de); end
      checks++; if (hsync !== exp_hs) begin errors++; $display("FAIL line_hsync hc=%0d got %b want %b", k, hsync, exp_hs); end
      checks++; if (ma !== 14'(k)) begin errors++; $display("FAIL line_ma hc=%0d got %h want %h", k, ma, 14'(k)); end
      step(1'b1);
      repeat (7) step(1'b0);
    end
    checks++; if (ra !== 5'd1) begin errors++; $display("FAIL line_wrap_ra got %0d want 1", ra); end
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL line_wrap_ma got %h want 0", ma); end
  endtask

  // Default frame: 31 rows of 8 rasters then 2 adjust lines with vsync.
  task automatic test_frame();
    int fl;
    logic [4:0]  exp_ra;
    logic        exp_de, exp_vs;
    logic [13:0] exp_ma;
    do_reset();
    for (int l = 0; l < 252; l++) begin
      fl     = l % 250;
      exp_ra = (fl < 248) ? 5'(fl % 8) : 5'(fl - 248);
      exp_de = (fl < 248);
      exp_vs = (fl >= 248);
      exp_ma = (fl < 248) ? 14'(32 * (fl / 8)) : 14'd992;
      checks++; if (ra !== exp_ra) begin errors++; $display("FAIL frame_ra line=%0d got %0d want %0d", l, ra, exp_ra); end
      checks++; if (de !== exp_de) begin errors++; $display("FAIL frame_de line=%0d got %b want %b", l, de, exp_de); end
      checks++; if (vsync !== exp_vs) begin errors++; $display("FAIL frame_vsync line=%0d got %b want %b", l, vsync, exp_vs); end
      checks++; if (ma !== exp_ma) begin errors++; $display("FAIL frame_ma line=%0d got %h want %h", l, ma, exp_ma); end
      ces(64);
    end
  endtask

  task automatic test_start_addr();
    do_reset();
    wr(5'd12, 8'h01);
    wr(5'd13, 8'h00);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rd_r13 got %h want 00", dout); end
    sel(5'd12);
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL rd_r12 got %h want 01", dout); end
    sel(5'd1);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rd_other got %h want 00", dout); end
    wr(5'd4, 8'd1);
    wr(5'd5, 8'd0);
    ces(16 * 64);
    for (int r = 0; r < 8; r++) begin
      checks++; if (ma !== 14'h0100) begin errors++; $display("FAIL start_ma0 ras=%0d got %h want 0100", r, ma); end
      ces(31);
      checks++; if (ma !== 14'h011f) begin errors++; $display("FAIL start_ma31 ras=%0d got %h want 011f", r, ma); end
      ces(33);
    end
    checks++; if (ma !== 14'h0120) begin errors++; $display("FAIL start_row1 got %h want 0120", ma); end
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL start_row1_ra got %0d want 0", ra); end
  endtask

  task automatic test_no_adj();
    int hs_seen = 0;
    do_reset();
    wr(5'd5, 8'd0);
    wr(5'd3, 8'h20);
    for (int l = 0; l < 248; l++) begin
      if (l == 247) begin
        checks++; if (ra !== 5'd7) begin errors++; $display("FAIL noadj_last_ra got %0d want 7", ra); end
        checks++; if (ma !== 14'd960) begin errors++; $display("FAIL noadj_last_ma got %h want %h", ma, 14'd960); end
      end
      for (int c = 0; c < 64; c++) begin
        if (hsync) hs_seen++;
        step(1'b1);
      end
    end
    checks++; if (hs_seen != 0) begin errors++; $display("FAIL noadj_hsync got %0d want 0", hs_seen); end
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL noadj_frame_ra got %0d want 0", ra); end
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL noadj_frame_ma got %h want 0", ma); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL noadj_frame_de got %b want 1", de); end
  endtask

  task automatic test_htotal_write();
    do_reset();
    ces(40);
    checks++; if (ma !== 14'd40) begin errors++; $display("FAIL ht_pre_ma got %h want %h", ma, 14'd40); end
    wr(5'd0, 8'd20);
    step(1'b1);
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL ht_wrap_ma got %h want 0", ma); end
    checks++; if (ra !== 5'd1) begin errors++; $display("FAIL ht_wrap_ra got %0d want 1", ra); end
    ces(20);
    checks++; if (ma !== 14'd20) begin errors++; $display("FAIL ht_mid_ma got %h want %h", ma, 14'd20); end
    checks++; if (ra !== 5'd1) begin errors++; $display("FAIL ht_mid_ra got %0d want 1", ra); end
    step(1'b1);
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL ht_line2_ma got %h want 0", ma); end
    checks++; if (ra !== 5'd2) begin errors++; $display("FAIL ht_line2_ra got %0d want 2", ra); end
    ces(21);
    checks++; if (ra !== 5'd3) begin errors++; $display("FAIL ht_line3_ra got %0d want 3", ra); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ces(248 * 64 + 5);
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL mr_pre_vsync got %b want 1", vsync); end
    sel(5'd0);
    reset = 1'b1; ce = 1'b1; cs = 1'b1; rs = 1'b1; di = 8'd5;
    @(posedge clock); #1;
    reset = 1'b0; ce = 1'b0; cs = 1'b0; rs = 1'b0;
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL mr_vsync got %b want 0", vsync); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL mr_hsync got %b want 0", hsync); end
    checks++; if (ma !== 14'h0) begin errors++; $display("FAIL mr_ma got %h want 0", ma); end
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL mr_ra got %0d want 0", ra); end
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL mr_de got %b want 1", de); end
    ces(63);
    checks++; if (ra !== 5'd0) begin errors++; $display("FAIL mr_r0_ra got %0d want 0", ra); end
    checks++; if (ma !== 14'd63) begin errors++; $display("FAIL mr_r0_ma got %h want %h", ma, 14'd63); end
    step(1'b1);
    checks++; if (ra !== 5'd1) begin errors++; $display("FAIL mr_wrap_ra got %0d want 1", ra); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_start_addr();
    test_no_adj();
    test_htotal_write();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crtc.md
CRTC -- requirements
Module: crtc

Interface
REQ-001 Parameter: MA_W, 14, width of the video memory address output.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ce  in  1  character clock enable; one pulse per 8-pixel character, aligned with the downstream shifter's 8-count wrap.
REQ-006 cs  in  1  CPU access strobe; 1 = write this cycle (ce-independent).
REQ-007 rs  in  1  0 = address register, 1 = data register.
REQ-008 di  in  8  CPU write data.
REQ-009 do  out  8  read data: R12/R13 contents when selected, else 8'h00.
REQ-010 de  out  1  display enable to the downstream pixel shifter.
REQ-011 hsync  out  1  horizontal sync, active-high.
REQ-012 vsync  out  1  vertical sync, active-high.
REQ-013 ma  out  MA_W  character/memory address.
REQ-014 ra  out  5  raster address within the character row.

Function
REQ-015 Register file: R0 htotal(8), R1 hdisp(8), R2 hsyncpos(8), R3 {vsw[7:4], hsw[3:0]}, R4 vtotal(7), R5 vadj(5), R6 vdisp(7), R7 vsyncpos(7), R9 maxras(5), R12/R13 start address (high 6 / low 8 bits); all other indices ignore writes.
REQ-016 A write with rs=0 loads a 5-bit index from di[4:0]; a write with rs=1 loads the indexed register from di, truncated to the register width; the new value takes effect on the next clock.
REQ-017 Horizontal counter hc advances by 1 on each ce; when hc==R0 it wraps to 0 on that ce (line length R0+1 characters).
REQ-018 Raster counter ra advances on each line wrap; when ra==R9 it wraps to 0 and row counter vc advances by 1.
REQ-019 Vertical FSM has two states. ROWS: counting character rows. ADJ: counting R5 extra rasters.
REQ-020 ROWS to ADJ when ra==R9 and vc==R4 at line wrap and R5!=0; if R5==0, go directly to a new frame (vc=0, ra=0, ROWS).
REQ-021 ADJ to ROWS (new frame) at the line wrap where the adjust counter == R5-1; ra counts through adjust lines.
REQ-022 de=1 iff hc<R1, vc<R6 and FSM==ROWS; R1>R0 holds de high for the full line; R1==0 or R6==0 forces de=0.
REQ-023 hsync rises on the ce where hc==R2 and lasts hsw characters; hsw==0 produces no hsync; a pulse crossing the line wrap continues until its count expires.
REQ-024 vsync rises at the start of the line where vc==R7 and ra==0, and lasts vsw lines; vsw==0 means 16 lines.
REQ-025 ma: at frame start ma=start; on each ce ma increments by 1 (MA_W wrap); at line wrap ma reloads the row base; at hc==R1 on the line where ra==R9, the row base is set to the current ma.
REQ-026 All outputs are functions of registered state only; no combinational path from cs/rs/di to de/hsync/vsync/ma/ra.
REQ-027 Register writes mid-line take effect immediately; if hc>R0 after a write, hc wraps on the next ce; if vc>R4, the frame ends at the next ra==R9 line wrap.

Reset
REQ-028 On reset: hc=0, ra=0, vc=0, adjust counter=0, FSM=ROWS, sync counters=0, index=0, and ma=row base=start address.
REQ-029 Outputs after reset: de per REQ-022 with counters at 0, hsync=0, vsync=0, ma=start address, ra=0, do=8'h00.
REQ-030 Register reset values come from the package defaults: R0=63, R1=32, R2=44, R3=8'h28, R4=30, R5=2, R6=31, R7=31, R9=7, R12=0, R13=0.
REQ-031 Reset mid-frame takes priority over ce and over CPU writes in the same cycle.

Structure
REQ-032 Shared package holds the register index constants, the default values and the FSM state enum.
REQ-033 One natural sub-module: crtc_regs (register file with CPU write/read port); the counters and FSM stay in crtc.

Verification
REQ-034 Defaults, ce every 8 clocks: line = 64 ce; de high for ce 0-31; hsync high for ce 44-51.
REQ-035 Defaults: frame = (30+1)*8+2 = 250 lines; vsync high for 2 lines starting at row 31 raster 0; de low from row 31 onward.
REQ-036 R12=8'h01, R13=8'h00, R1=32, R9=7: row 0 ma = 0x0100..0x011F on every raster; row 1 starts at 0x0120.
REQ-037 R5=0: no ADJ state; frame = 248 lines. R3[3:0]=0: hsync stays 0 for the whole frame.
REQ-038 Write R0=20 while hc=40: hc wraps to 0 on the next ce; the following lines are 21 ce long.
REQ-039 Assert reset mid-frame together with a ce and a write: next cycle hc=ra=vc=0, vsync=0, the register is unchanged, and ma=start address.
